// File: rtl/ongoru_pkg.sv
// ---------------------------------------------------------------------------
// ongoru_pkg
// Shared types for the branch-predictor access controller, the predictor and
// the execute stage.
//   durum_e       : controller states (NORMAL / DRAIN / FLUSH)
//   guncelleme_t  : one training update {ps[31:0], atladi, yanlis} = 34 bits
//   doyumlu_artir : 16-bit saturating increment helper
// ---------------------------------------------------------------------------
package ongoru_pkg;

    typedef enum logic [1:0] {
        DURUM_NORMAL = 2'd0,
        DURUM_DRAIN  = 2'd1,
        DURUM_FLUSH  = 2'd2
    } durum_e;

    typedef struct packed {
        logic [31:0] ps;
        logic        atladi;
        logic        yanlis;
    } guncelleme_t;

    localparam int GUNCELLEME_W = 34;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] doyumlu_artir(input logic [15:0] deger);
        logic [15:0] sonuc;
        if (deger == 16'hFFFF) begin
            sonuc = deger;
        end else begin
            sonuc = deger + 16'd1;
        end
        return sonuc;
    endfunction

endpackage

// File: rtl/ongoru_erisim_denetleyici_if.sv
// ---------------------------------------------------------------------------
// ongoru_erisim_denetleyici_if
// Bundles the fetch request, execute update and predictor-side signals of the
// access controller. Signal suffixes are from the controller's point of view.
//   slave  : controller side (takes fetch/execute inputs, drives the rest)
//   master : environment side (fetch, execute and predictor)
// ---------------------------------------------------------------------------
interface ongoru_erisim_denetleyici_if;

    // fetch side
    logic        getir_istek_gecerli_i;
    logic [31:0] getir_ps_i;
    logic        getir_hazir_o;
    // execute side
    logic        yurut_gecerli_i;
    logic [31:0] yurut_ps_i;
    logic        yurut_atladi_i;
    logic        yanlis_tahmin_i;
    logic [31:0] yurut_hedef_ps_i;
    logic        yurut_hazir_o;
    // predictor side
    logic        tahmin_ps_gecerli_o;
    logic [31:0] tahmin_ps_o;
    logic        yurut_ps_gecerli_o;
    logic [31:0] yurut_ps_o;
    logic        yurut_atladi_o;
    logic        yanlis_tahmin_o;
    // redirect and statistics
    logic        yonlendir_gecerli_o;
    logic [31:0] yonlendir_ps_o;
    logic [15:0] yanlis_sayac_o;

    modport slave (
        input  getir_istek_gecerli_i, getir_ps_i,
        input  yurut_gecerli_i, yurut_ps_i, yurut_atladi_i, yanlis_tahmin_i, yurut_hedef_ps_i,
        output getir_hazir_o, yurut_hazir_o,
        output tahmin_ps_gecerli_o, tahmin_ps_o,
        output yurut_ps_gecerli_o, yurut_ps_o, yurut_atladi_o, yanlis_tahmin_o,
        output yonlendir_gecerli_o, yonlendir_ps_o, yanlis_sayac_o
    );

    modport master (
        output getir_istek_gecerli_i, getir_ps_i,
        output yurut_gecerli_i, yurut_ps_i, yurut_atladi_i, yanlis_tahmin_i, yurut_hedef_ps_i,
        input  getir_hazir_o, yurut_hazir_o,
        input  tahmin_ps_gecerli_o, tahmin_ps_o,
        input  yurut_ps_gecerli_o, yurut_ps_o, yurut_atladi_o, yanlis_tahmin_o,
        input  yonlendir_gecerli_o, yonlendir_ps_o, yanlis_sayac_o
    );

endinterface

// File: rtl/ongoru_erisim_denetleyici_chk.sv
// ---------------------------------------------------------------------------
// ongoru_erisim_denetleyici_chk
// Protocol properties of the access controller.
//   tahmin_gecerli_i / yurut_gecerli_i : registered predictor ops
//   cek_i / bos_i, it_i / dolu_i        : FIFO pop/push and status
//   sayac_i                             : mispredict counter
// ---------------------------------------------------------------------------
module ongoru_erisim_denetleyici_chk (
    input logic        clk_i,
    input logic        rst_i,
    input logic        tahmin_gecerli_i,
    input logic        yurut_gecerli_i,
    input logic        cek_i,
    input logic        bos_i,
    input logic        it_i,
    input logic        dolu_i,
    input logic [15:0] sayac_i
);

    a_tek_islem: assert property (@(posedge clk_i) disable iff (rst_i)
        !(tahmin_gecerli_i && yurut_gecerli_i));

    a_bos_cekme: assert property (@(posedge clk_i) disable iff (rst_i)
        cek_i |-> !bos_i);

    a_dolu_itme: assert property (@(posedge clk_i) disable iff (rst_i)
        it_i |-> !dolu_i);

    a_sayac_doyum: assert property (@(posedge clk_i) disable iff (rst_i)
        (sayac_i == 16'hFFFF) |=> (sayac_i == 16'hFFFF));

endmodule

// File: rtl/ongoru_erisim_denetleyici_guncelleme_fifo.sv
// ---------------------------------------------------------------------------
// guncelleme_fifo
// In-order synchronous FIFO for predictor training updates.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/veri_i: write request and data (ignored when full)
//   pop_i/veri_o : read request and head data (ignored when empty)
//   full_o, empty_o, count_o : occupancy status
// DERINLIK must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module guncelleme_fifo
    import ongoru_pkg::*;
#(
    parameter int DERINLIK = 4,
    localparam int PW = $clog2(DERINLIK),
    localparam int CW = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  guncelleme_t   veri_i,
    input  logic          pop_i,
    output guncelleme_t   veri_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] yaz_ptr_q;
    logic [PW-1:0] oku_ptr_q;
    logic [CW-1:0] sayi_q;
    guncelleme_t   mem_q [DERINLIK];
    logic          yaz;
    logic          oku;

    assign full_o  = (sayi_q == CW'(DERINLIK));
    assign empty_o = (sayi_q == {CW{1'b0}});
    assign count_o = sayi_q;
    assign yaz     = push_i && !full_o;
    assign oku     = pop_i && !empty_o;
    // Head is read straight from storage, so a same-cycle push never bypasses.
    assign veri_o  = mem_q[oku_ptr_q];

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yaz_ptr_q <= {PW{1'b0}};
            oku_ptr_q <= {PW{1'b0}};
            sayi_q    <= {CW{1'b0}};
        end else begin
            if (yaz) begin
                yaz_ptr_q <= yaz_ptr_q + PW'(1);
            end
            if (oku) begin
                oku_ptr_q <= oku_ptr_q + PW'(1);
            end
            case ({yaz, oku})
                2'b10:   sayi_q <= sayi_q + CW'(1);
                2'b01:   sayi_q <= sayi_q - CW'(1);
                default: sayi_q <= sayi_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (!rst_i && yaz) begin
            mem_q[yaz_ptr_q] <= veri_i;
        end
    end

endmodule

// File: rtl/ongoru_erisim_denetleyici.sv
// ---------------------------------------------------------------------------
// ongoru_erisim_denetleyici
// Arbitrates the single predictor port between fetch lookups and buffered
// execute updates, issues at most one op per cycle, and raises a one-cycle
// fetch redirect on each accepted mispredict.
//   clk_i : clock
//   rst_i : synchronous reset, active-high
//   bus   : fetch request, execute update, predictor ops, redirect, counter
// ---------------------------------------------------------------------------
module ongoru_erisim_denetleyici
    import ongoru_pkg::*;
#(
    parameter int DERINLIK       = 4,
    parameter int DRAIN_ALT_ESIK = 1,
    parameter int FLUSH_CEVRIM   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ongoru_erisim_denetleyici_if.slave  bus
);

    localparam int          CW        = $clog2(DERINLIK) + 1;
    localparam int          FW        = (FLUSH_CEVRIM > 1) ? $clog2(FLUSH_CEVRIM) : 1;
    localparam logic [FW-1:0] FLUSH_YUK = FW'(FLUSH_CEVRIM - 1);

    durum_e        durum_q, durum_d;
    logic [FW-1:0] flush_sayac_q, flush_sayac_d;
    logic [CW-1:0] sayi_d;

    logic          fifo_dolu, fifo_bos;
    logic [CW-1:0] fifo_sayi;
    guncelleme_t   fifo_bas, fifo_giris;

    logic getir_hazir, yurut_hazir;
    logic tahmin_kabul, guncelleme_kabul, yanlis_kabul, cek;

    logic        tahmin_gecerli_q, yurut_gecerli_q, yonlendir_gecerli_q;
    logic [31:0] tahmin_ps_q, yurut_ps_q, yonlendir_ps_q;
    logic        yurut_atladi_q, yanlis_tahmin_q;
    logic [15:0] yanlis_sayac_q;

    // Ready is deliberately blind to a same-cycle pop and to execute inputs.
    assign yurut_hazir      = !fifo_dolu;
    assign getir_hazir      = (durum_q == DURUM_NORMAL) && !fifo_dolu;
    assign tahmin_kabul     = bus.getir_istek_gecerli_i && getir_hazir;
    assign guncelleme_kabul = bus.yurut_gecerli_i && yurut_hazir;
    assign yanlis_kabul     = guncelleme_kabul && bus.yanlis_tahmin_i;
    // Predict wins the port; otherwise drain one queued update.
    assign cek              = !tahmin_kabul && !fifo_bos;

    assign fifo_giris.ps     = bus.yurut_ps_i;
    assign fifo_giris.atladi = bus.yurut_atladi_i;
    assign fifo_giris.yanlis = bus.yanlis_tahmin_i;

    guncelleme_fifo #(.DERINLIK(DERINLIK)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (guncelleme_kabul),
        .veri_i  (fifo_giris),
        .pop_i   (cek),
        .veri_o  (fifo_bas),
        .full_o  (fifo_dolu),
        .empty_o (fifo_bos),
        .count_o (fifo_sayi)
    );

    // Occupancy after this cycle's push/pop, used by the state transitions.
    always_comb begin
        sayi_d = fifo_sayi;
        case ({guncelleme_kabul, cek})
            2'b10:   sayi_d = fifo_sayi + CW'(1);
            2'b01:   sayi_d = fifo_sayi - CW'(1);
            default: sayi_d = fifo_sayi;
        endcase
    end

    // Next-state and flush-window counter logic.
    always_comb begin
        durum_d       = durum_q;
        flush_sayac_d = flush_sayac_q;
        case (durum_q)
            DURUM_NORMAL: begin
                if (yanlis_kabul) begin
                    durum_d       = DURUM_FLUSH;
                    flush_sayac_d = FLUSH_YUK;
                end else if (sayi_d == CW'(DERINLIK)) begin
                    durum_d = DURUM_DRAIN;
                end else begin
                    durum_d = DURUM_NORMAL;
                end
            end
            DURUM_DRAIN: begin
                if (yanlis_kabul) begin
                    durum_d       = DURUM_FLUSH;
                    flush_sayac_d = FLUSH_YUK;
                end else if (sayi_d <= CW'(DRAIN_ALT_ESIK)) begin
                    durum_d = DURUM_NORMAL;
                end else begin
                    durum_d = DURUM_DRAIN;
                end
            end
            DURUM_FLUSH: begin
                if (yanlis_kabul) begin
                    // A fresh mispredict restarts the whole blocking window.
                    durum_d       = DURUM_FLUSH;
                    flush_sayac_d = FLUSH_YUK;
                end else if (flush_sayac_q == {FW{1'b0}}) begin
                    durum_d = (sayi_d == CW'(DERINLIK)) ? DURUM_DRAIN : DURUM_NORMAL;
                end else begin
                    flush_sayac_d = flush_sayac_q - FW'(1);
                end
            end
            default: begin
                durum_d       = DURUM_NORMAL;
                flush_sayac_d = {FW{1'b0}};
            end
        endcase
    end

    // State and flush counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q       <= DURUM_NORMAL;
            flush_sayac_q <= {FW{1'b0}};
        end else begin
            durum_q       <= durum_d;
            flush_sayac_q <= flush_sayac_d;
        end
    end

    // Registered predictor ops, redirect pulse and mispredict counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tahmin_gecerli_q    <= 1'b0;
            tahmin_ps_q         <= 32'd0;
            yurut_gecerli_q     <= 1'b0;
            yurut_ps_q          <= 32'd0;
            yurut_atladi_q      <= 1'b0;
            yanlis_tahmin_q     <= 1'b0;
            yonlendir_gecerli_q <= 1'b0;
            yonlendir_ps_q      <= 32'd0;
            yanlis_sayac_q      <= 16'd0;
        end else begin
            tahmin_gecerli_q    <= tahmin_kabul;
            yurut_gecerli_q     <= cek;
            yonlendir_gecerli_q <= yanlis_kabul;
            if (tahmin_kabul) begin
                tahmin_ps_q <= bus.getir_ps_i;
            end
            if (cek) begin
                yurut_ps_q      <= fifo_bas.ps;
                yurut_atladi_q  <= fifo_bas.atladi;
                yanlis_tahmin_q <= fifo_bas.yanlis;
            end
            if (yanlis_kabul) begin
                yonlendir_ps_q <= bus.yurut_hedef_ps_i;
                yanlis_sayac_q <= doyumlu_artir(yanlis_sayac_q);
            end
        end
    end

    assign bus.getir_hazir_o       = getir_hazir;
    assign bus.yurut_hazir_o       = yurut_hazir;
    assign bus.tahmin_ps_gecerli_o = tahmin_gecerli_q;
    assign bus.tahmin_ps_o         = tahmin_ps_q;
    assign bus.yurut_ps_gecerli_o  = yurut_gecerli_q;
    assign bus.yurut_ps_o          = yurut_ps_q;
    assign bus.yurut_atladi_o      = yurut_atladi_q;
    assign bus.yanlis_tahmin_o     = yanlis_tahmin_q;
    assign bus.yonlendir_gecerli_o = yonlendir_gecerli_q;
    assign bus.yonlendir_ps_o      = yonlendir_ps_q;
    assign bus.yanlis_sayac_o      = yanlis_sayac_q;

    ongoru_erisim_denetleyici_chk u_chk (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tahmin_gecerli_i (tahmin_gecerli_q),
        .yurut_gecerli_i  (yurut_gecerli_q),
        .cek_i            (cek),
        .bos_i            (fifo_bos),
        .it_i             (guncelleme_kabul),
        .dolu_i           (fifo_dolu),
        .sayac_i          (yanlis_sayac_q)
    );

endmodule

// File: tb/tb_ongoru_erisim_denetleyici.sv
// ---------------------------------------------------------------------------
// tb_ongoru_erisim_denetleyici
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based reference model of the controller.
// ---------------------------------------------------------------------------
module tb_ongoru_erisim_denetleyici;

    localparam int DER   = 4;
    localparam int ESIK  = 1;
    localparam int FLUSH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ongoru_erisim_denetleyici_if bus();

    ongoru_erisim_denetleyici #(
        .DERINLIK       (DER),
        .DRAIN_ALT_ESIK (ESIK),
        .FLUSH_CEVRIM   (FLUSH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_karsilastirma = 0;
    int n_uyumsuz       = 0;

    // Reference model state
    typedef struct {
        logic [31:0] ps;
        logic        at;
        logic        yt;
    } upd_t;

    upd_t        kuyruk[$];
    int          flush_kalan = 0;   // fetch-blocked cycles still owed to a redirect
    bit          bosaltma    = 0;   // draining a full queue
    bit          bilinen     = 0;   // model state meaningful (after first reset)
    logic        e_tg = 1'b0, e_yg = 1'b0, e_rg = 1'b0, e_yat = 1'b0, e_yyt = 1'b0;
    logic [31:0] e_tps = 32'd0, e_yps = 32'd0, e_rps = 32'd0;
    logic [15:0] e_say = 16'd0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        n_karsilastirma++;
        if (gozlenen !== beklenen) begin
            n_uyumsuz++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic adim(input bit r, input bit gv, input logic [31:0] gps,
                        input bit yv, input logic [31:0] yps, input bit yat,
                        input bit ymis, input logic [31:0] hedef);
        bit   ghazir, yhazir, pacc, itme, mis;
        upd_t u;
        @(negedge clk);
        rst                       = r;
        bus.getir_istek_gecerli_i = gv;
        bus.getir_ps_i            = gps;
        bus.yurut_gecerli_i       = yv;
        bus.yurut_ps_i            = yps;
        bus.yurut_atladi_i        = yat;
        bus.yanlis_tahmin_i       = ymis;
        bus.yurut_hedef_ps_i      = hedef;
        #1;
        yhazir = (kuyruk.size() < DER);
        ghazir = yhazir && !bosaltma && (flush_kalan == 0);
        if (bilinen) begin
            kontrol("getir_hazir", {31'd0, bus.getir_hazir_o}, {31'd0, ghazir});
            kontrol("yurut_hazir", {31'd0, bus.yurut_hazir_o}, {31'd0, yhazir});
        end
        if (r) begin
            kuyruk.delete();
            flush_kalan = 0;
            bosaltma    = 0;
            e_tg = 1'b0; e_yg = 1'b0; e_rg = 1'b0; e_yat = 1'b0; e_yyt = 1'b0;
            e_tps = 32'd0; e_yps = 32'd0; e_rps = 32'd0; e_say = 16'd0;
            bilinen = 1;
        end else begin
            pacc = gv && ghazir;
            itme = yv && yhazir;
            mis  = itme && ymis;
            e_tg = pacc;
            if (pacc) e_tps = gps;
            e_yg = 1'b0;
            if (!pacc && kuyruk.size() > 0) begin
                u     = kuyruk.pop_front();
                e_yg  = 1'b1;
                e_yps = u.ps;
                e_yat = u.at;
                e_yyt = u.yt;
            end
            if (itme) kuyruk.push_back('{ps: yps, at: yat, yt: ymis});
            e_rg = mis;
            if (mis) begin
                e_rps = hedef;
                if (e_say != 16'hFFFF) e_say = e_say + 16'd1;
            end
            // Mode bookkeeping from the queue length after this cycle.
            if (mis) begin
                flush_kalan = FLUSH;
                bosaltma    = 0;
            end else if (flush_kalan > 0) begin
                flush_kalan--;
                if (flush_kalan == 0) bosaltma = (kuyruk.size() == DER);
            end else if (!bosaltma) begin
                bosaltma = (kuyruk.size() == DER);
            end else if (kuyruk.size() <= ESIK) begin
                bosaltma = 0;
            end
        end
        @(posedge clk);
        #1;
        kontrol("tahmin_gecerli",  {31'd0, bus.tahmin_ps_gecerli_o}, {31'd0, e_tg});
        kontrol("tahmin_ps",       bus.tahmin_ps_o, e_tps);
        kontrol("yurut_gecerli",   {31'd0, bus.yurut_ps_gecerli_o}, {31'd0, e_yg});
        kontrol("yurut_ps",        bus.yurut_ps_o, e_yps);
        kontrol("yurut_atladi",    {31'd0, bus.yurut_atladi_o}, {31'd0, e_yat});
        kontrol("yanlis_tahmin",   {31'd0, bus.yanlis_tahmin_o}, {31'd0, e_yyt});
        kontrol("yonlendir_gec",   {31'd0, bus.yonlendir_gecerli_o}, {31'd0, e_rg});
        kontrol("yonlendir_ps",    bus.yonlendir_ps_o, e_rps);
        kontrol("yanlis_sayac",    {16'd0, bus.yanlis_sayac_o}, {16'd0, e_say});
    endtask

    task automatic bos_adim(input bit gv);
        adim(1'b0, gv, 32'h0000_0F00, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        bus.getir_istek_gecerli_i = 1'b0;
        bus.getir_ps_i            = 32'd0;
        bus.yurut_gecerli_i       = 1'b0;
        bus.yurut_ps_i            = 32'd0;
        bus.yurut_atladi_i        = 1'b0;
        bus.yanlis_tahmin_i       = 1'b0;
        bus.yurut_hedef_ps_i      = 32'd0;

        // Reset
        adim(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        adim(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // 1: single predict
        adim(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        bos_adim(1'b0);

        // 2: single taken update, no fetch
        adim(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'd0);
        bos_adim(1'b0);
        bos_adim(1'b0);

        // 3: continuous fetch while four updates fill the queue
        for (int i = 1; i <= 4; i++)
            adim(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b1, 32'(i * 16), 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) bos_adim(1'b1);

        // 4/5: mispredict, then a second one inside the flush window
        adim(1'b0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0400);
        adim(1'b0, 1'b1, 32'h0000_2004, 1'b1, 32'h0000_0304, 1'b0, 1'b1, 32'h0000_0500);
        for (int i = 0; i < 4; i++) bos_adim(1'b1);

        // 6: reset with three queued updates
        for (int i = 0; i < 3; i++)
            adim(1'b0, 1'b1, 32'h3000, 1'b1, 32'h0000_0600 + 32'(i), 1'b1, 1'b0, 32'd0);
        adim(1'b1, 1'b1, 32'h3000, 1'b1, 32'h0000_0700, 1'b1, 1'b1, 32'h0000_0800);
        bos_adim(1'b0);
        bos_adim(1'b0);

        // Randomized traffic in phases of differing pressure
        for (int i = 0; i < 4000; i++) begin
            int faz;
            int gp, yp, mp;
            faz = (i / 400) % 4;
            case (faz)
                0:       begin gp = 80; yp = 50; mp = 10; end
                1:       begin gp = 20; yp = 90; mp = 10; end
                2:       begin gp = 95; yp = 90; mp = 5;  end
                default: begin gp = 50; yp = 60; mp = 30; end
            endcase
            adim($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < gp, $urandom,
                 $urandom_range(0, 99) < yp, $urandom, 1'($urandom),
                 $urandom_range(0, 99) < mp, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_uyumsuz);
        $finish;
    end

endmodule
